cla_serial_add_ctrl: RTL and testbench

Nibble-serial wide adder/subtractor controller. Accepts a pair of WIDTH-bit operands over a valid/ready handshake and sequences one shared 4-bit carry-lookahead slice across the operand, least-significant nibble first, over WIDTH/4 cycles. It holds the inter-slice carry in a register and returns the sum, carry-out and signed overflow on a second valid/ready handshake. It sits between operand producers and the result consumer wherever area matters more than single-cycle latency.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla4_slice.sv | 39 +++
 rtl/cla_serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// Imported by the controller and the slice.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int slices(input int w);
    return w / SLICE_W;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
// All generate/propagate lookahead is local to this module.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (&w_p & cin);

  assign s    = w_p ^ w_c[3:0];
  assign cout = w_c[4];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial add/sub controller: one shared CLA slice,
// LS nibble first, carry held in a register between slices.
module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int SLICES = slices(WIDTH);
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int MSB    = WIDTH - 1;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_ovf;
  logic [IDX_W-1:0]   r_idx;
  logic [SLICE_W-1:0] w_na;
  logic [SLICE_W-1:0] w_nb;
  logic [SLICE_W-1:0] w_ns;
  logic               w_ncout;
  logic               w_last;

  assign w_na   = r_a[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_nb   = r_b[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_last = (r_idx == IDX_W'(SLICES - 1));

  cla4_slice u_slice (
    .a    (w_na),
    .b    (w_nb),
    .cin  (r_carry),
    .s    (w_ns),
    .cout (w_ncout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state == RUN);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= in_a;
          r_b     <= in_sub ? ~in_b : in_b;
          r_carry <= in_sub;
          r_ovf   <= 1'b0;
          r_idx   <= '0;
        end
        RUN: begin
          r_sum[int'(r_idx)*SLICE_W +: SLICE_W] <= w_ns;
          r_carry <= w_ncout;
          r_idx   <= r_idx + IDX_W'(1);
          // sum MSB only exists on the slice output in the last cycle
          if (w_last)
            r_ovf <= (r_a[MSB] == r_b[MSB])
                   && (w_ns[SLICE_W-1] != r_a[MSB]);
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_carry;
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed + randomised bench for cla_serial_add_ctrl.
// Inputs change and outputs are sampled 1ns after rising edges.
module tb_cla_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_res = 0;

  always #5 clk = ~clk;

  cla_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".ov"}, 32'(out_valid), 0);
    check({tag, ".ir"}, 32'(in_ready), 1);
    check({tag, ".bz"}, 32'(busy), 0);
  endtask

  // A±B with expectations from the pre-computed or model values
  task automatic run_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic        s,
                        input logic [15:0] e_sum,
                        input logic        e_cout,
                        input logic        e_ovf,
                        input int          pre,
                        input int          hold,
                        input bit          full);
    int n;
    logic [15:0] f_sum;
    logic f_c, f_o;
    for (int i = 0; i < pre; i++) tick();
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("accept_wait", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_sub = ~s;
    if (full) check("busy_run", 32'(busy), 1);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("latency", n, 4);
    check("sum", out_sum, e_sum);
    check("cout", 32'(out_cout), 32'(e_cout));
    check("ovf", 32'(out_ovf), 32'(e_ovf));
    if (full) begin
      check("ir_done", 32'(in_ready), 0);
      check("bz_done", 32'(busy), 0);
    end
    f_sum = out_sum; f_c = out_cout; f_o = out_ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      tick();
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_sum", out_sum, f_sum);
      check("bp_cout", 32'(out_cout), 32'(f_c));
      check("bp_ovf", 32'(out_ovf), 32'(f_o));
      check("bp_ir", 32'(in_ready), 0);
      check("bp_bz", 32'(busy), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_res++;
    if (full) chk_idle("post");
  endtask

  task automatic model(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic        s,
                       output logic [15:0] e_sum,
                       output logic        e_c,
                       output logic        e_o);
    logic [16:0] ext;
    logic [15:0] bp;
    bp    = s ? ~b : b;
    ext   = {1'b0, a} + {1'b0, bp} + {16'd0, s};
    e_sum = ext[15:0];
    e_c   = ext[16];
    e_o   = (a[15] == bp[15]) && (e_sum[15] != a[15]);
  endtask

  initial begin
    logic [15:0] ra, rb, es;
    logic rs, ec, eo;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    #12;
    chk_idle("rst");
    check("rst.sum", out_sum, 0);
    check("rst.cout", 32'(out_cout), 0);
    check("rst.ovf", 32'(out_ovf), 0);
    rst_n = 1'b1;
    tick();

    run_op(16'h1234, 16'h4321, 0, 16'h5555, 0, 0, 0, 0, 1);
    run_op(16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1, 0, 1);
    run_op(16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0, 0, 1);
    run_op(16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0, 2, 0, 1);
    run_op(16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 0, 0, 1);
    run_op(16'hA5A5, 16'h5A5A, 0, 16'hFFFF, 0, 0, 0, 10, 1);
    run_op(16'h1000, 16'h1000, 1, 16'h0000, 1, 0, 0, 0, 1);

    // reset while idx==2
    in_a = 16'h1111; in_b = 16'h2222; in_sub = 0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid.busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_idle("mid.rst");
    check("mid.sum", out_sum, 0);
    check("mid.cout", 32'(out_cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("mid.rel");
    run_op(16'h00FF, 16'h0001, 0, 16'h0100, 0, 0, 0, 0, 1);

    n_res = 0;
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, es, ec, eo);
      run_op(ra, rb, rs, es, ec, eo,
             $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    check("rand.count", n_res, 1000);
    n = 0;
    while (out_valid && n < 5) begin tick(); n++; end
    chk_idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
